// File: rtl/psram_xfer_arb.sv
// Round-robin arbiter between the config and bus requesters for the single psram_core transfer port.
// Optional WAIT-state watchdog is enabled by defining PSRAM_ARB_TIMEOUT_EN.
module psram_xfer_arb #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    cfg_req_i,
   input  logic                    cfg_we_i,
   input  logic [ADDR_WIDTH-1:0]   cfg_addr_i,
   input  logic [7:0]              cfg_wdata_i,
   output logic                    cfg_ack_o,
   output logic [7:0]              cfg_rdata_o,
   input  logic                    bus_req_i,
   input  logic                    bus_we_i,
   input  logic [ADDR_WIDTH-1:0]   bus_addr_i,
   input  logic [DATA_WIDTH-1:0]   bus_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] bus_wmask_i,
   output logic                    bus_ack_o,
   output logic [DATA_WIDTH-1:0]   bus_rdata_o,
   input  logic [7:0]              recy_i,
   output logic                    xfer_valid_o,
   output logic                    xfer_rdwr_o,
   output logic                    xfer_cfg_o,
   output logic [ADDR_WIDTH-1:0]   xfer_addr_o,
   output logic [DATA_WIDTH-1:0]   xfer_wdata_o,
   output logic [DATA_WIDTH/8-1:0] xfer_wmask_o,
   input  logic                    core_done_i,
   input  logic [DATA_WIDTH-1:0]   core_rdata_i,
   output logic                    busy_o,
   output logic                    err_o
);

   localparam int MASK_WIDTH = DATA_WIDTH / 8;
   localparam logic [MASK_WIDTH-1:0] CFG_MASK = {{(MASK_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RECY} state_t;

   state_t     state;
   state_t     state_next;
   logic       last_bus;
   logic [7:0] recy_cnt;
   logic       grant_any;
   logic       grant_cfg;
   logic       finish;
   logic       timeout;

`ifdef PSRAM_ARB_TIMEOUT_EN
   logic [15:0] wait_cnt;

   // Counts cycles spent in WAIT; cleared whenever the FSM is elsewhere.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wait_cnt <= 16'd0;
      end else if (state == WAIT) begin
         wait_cnt <= wait_cnt + 16'd1;
      end else begin
         wait_cnt <= 16'd0;
      end
   end

   assign timeout = (state == WAIT) && !core_done_i && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout = 1'b0;
`endif

   assign finish       = (state == WAIT) && (core_done_i || timeout);
   assign xfer_valid_o = (state == ISSUE);
   assign busy_o       = (state != IDLE);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Config wins a tie only when the bus held the last grant.
   always_comb begin
      state_next = state;
      grant_any  = 1'b0;
      grant_cfg  = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_req_i || bus_req_i) begin
               grant_any  = 1'b1;
               grant_cfg  = cfg_req_i && (!bus_req_i || last_bus);
               state_next = ISSUE;
            end
         end
         ISSUE: state_next = WAIT;
         WAIT: begin
            if (finish) begin
               state_next = (recy_i == 8'd0) ? IDLE : RECY;
            end
         end
         RECY: begin
            if (recy_cnt <= 8'd1) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Latches the winner's fields and returns completion; acks and rdata are registered.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_bus     <= 1'b1;
         recy_cnt     <= 8'd0;
         xfer_rdwr_o  <= 1'b0;
         xfer_cfg_o   <= 1'b0;
         xfer_addr_o  <= '0;
         xfer_wdata_o <= '0;
         xfer_wmask_o <= '0;
         cfg_ack_o    <= 1'b0;
         cfg_rdata_o  <= 8'd0;
         bus_ack_o    <= 1'b0;
         bus_rdata_o  <= '0;
         err_o        <= 1'b0;
      end else begin
         cfg_ack_o <= 1'b0;
         bus_ack_o <= 1'b0;
         err_o     <= 1'b0;
         if (grant_any) begin
            last_bus   <= !grant_cfg;
            xfer_cfg_o <= grant_cfg;
            if (grant_cfg) begin
               xfer_rdwr_o  <= !cfg_we_i;
               xfer_addr_o  <= cfg_addr_i;
               xfer_wdata_o <= {{(DATA_WIDTH-8){1'b0}}, cfg_wdata_i};
               xfer_wmask_o <= CFG_MASK;
            end else begin
               xfer_rdwr_o  <= !bus_we_i;
               xfer_addr_o  <= bus_addr_i;
               xfer_wdata_o <= bus_wdata_i;
               xfer_wmask_o <= bus_wmask_i;
            end
         end
         if (finish) begin
            recy_cnt <= recy_i;
            err_o    <= timeout;
            if (xfer_cfg_o) begin
               cfg_ack_o <= 1'b1;
               if (timeout) begin
                  cfg_rdata_o <= 8'd0;
               end else if (xfer_rdwr_o) begin
                  cfg_rdata_o <= core_rdata_i[7:0];
               end
            end else begin
               bus_ack_o <= 1'b1;
               if (timeout) begin
                  bus_rdata_o <= '0;
               end else if (xfer_rdwr_o) begin
                  bus_rdata_o <= core_rdata_i;
               end
            end
         end else if (state == RECY) begin
            recy_cnt <= recy_cnt - 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_psram_xfer_arb.sv
// Directed testbench for psram_xfer_arb: single transfers, round-robin, recovery gap,
// async reset during WAIT, and the watchdog when PSRAM_ARB_TIMEOUT_EN is defined.
module tb_psram_xfer_arb;

   logic        clk;
   logic        rst_n;
   logic        cfg_req;
   logic        cfg_we;
   logic [31:0] cfg_addr;
   logic [7:0]  cfg_wdata;
   logic        cfg_ack;
   logic [7:0]  cfg_rdata;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [63:0] bus_wdata;
   logic [7:0]  bus_wmask;
   logic        bus_ack;
   logic [63:0] bus_rdata;
   logic [7:0]  recy;
   logic        xfer_valid;
   logic        xfer_rdwr;
   logic        xfer_cfg;
   logic [31:0] xfer_addr;
   logic [63:0] xfer_wdata;
   logic [7:0]  xfer_wmask;
   logic        core_done;
   logic [63:0] core_rdata;
   logic        busy;
   logic        err;

   int check_count = 0;
   int error_count = 0;

   psram_xfer_arb #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(64),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
      .cfg_ack_o(cfg_ack), .cfg_rdata_o(cfg_rdata),
      .bus_req_i(bus_req), .bus_we_i(bus_we), .bus_addr_i(bus_addr), .bus_wdata_i(bus_wdata),
      .bus_wmask_i(bus_wmask), .bus_ack_o(bus_ack), .bus_rdata_o(bus_rdata),
      .recy_i(recy),
      .xfer_valid_o(xfer_valid), .xfer_rdwr_o(xfer_rdwr), .xfer_cfg_o(xfer_cfg),
      .xfer_addr_o(xfer_addr), .xfer_wdata_o(xfer_wdata), .xfer_wmask_o(xfer_wmask),
      .core_done_i(core_done), .core_rdata_i(core_rdata),
      .busy_o(busy), .err_o(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, " xfer_valid"}, 64'(xfer_valid), 64'd0);
      check_output({tag, " busy"}, 64'(busy), 64'd0);
      check_output({tag, " acks"}, 64'({cfg_ack, bus_ack, err}), 64'd0);
      check_output({tag, " cfg_rdata"}, 64'(cfg_rdata), 64'd0);
      check_output({tag, " bus_rdata"}, bus_rdata, 64'd0);
      check_output({tag, " xfer_fields"}, 64'({xfer_rdwr, xfer_cfg, xfer_wmask}), 64'd0);
      check_output({tag, " xfer_addr"}, 64'(xfer_addr), 64'd0);
      check_output({tag, " xfer_wdata"}, xfer_wdata, 64'd0);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation watchdog expired");
   end

   initial begin
      rst_n = 1'b0; cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; bus_wmask = '0;
      recy = 8'd0; core_done = 1'b0; core_rdata = '0;
      step(); step();
      check_all_zero("reset");
      rst_n = 1'b1;
      step();

      // Single bus write with no recovery gap.
      bus_req = 1'b1; bus_we = 1'b1; bus_addr = 32'h100;
      bus_wdata = 64'h1122334455667788; bus_wmask = 8'hFF;
      step();
      check_output("wr issue valid", 64'(xfer_valid), 64'd1);
      check_output("wr issue rdwr/cfg", 64'({xfer_rdwr, xfer_cfg}), 64'd0);
      check_output("wr issue addr", 64'(xfer_addr), 64'h100);
      check_output("wr issue wdata", xfer_wdata, 64'h1122334455667788);
      check_output("wr issue wmask", 64'(xfer_wmask), 64'hFF);
      step();
      check_output("wr wait valid", 64'(xfer_valid), 64'd0);
      check_output("wr wait busy", 64'(busy), 64'd1);
      check_output("wr wait no ack", 64'(bus_ack), 64'd0);
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      check_output("wr bus_ack", 64'(bus_ack), 64'd1);
      check_output("wr cfg_ack", 64'(cfg_ack), 64'd0);
      check_output("wr busy at ack", 64'(busy), 64'd0);
      check_output("wr no rdata capture", bus_rdata, 64'd0);
      bus_req = 1'b0;
      step();
      check_output("wr ack one cycle", 64'(bus_ack), 64'd0);
      check_output("wr idle valid", 64'(xfer_valid), 64'd0);

      // Config read: low byte of core data, bus rdata untouched.
      cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 32'h4; cfg_wdata = 8'h5A;
      step();
      check_output("cfg issue valid", 64'(xfer_valid), 64'd1);
      check_output("cfg issue rdwr/cfg", 64'({xfer_rdwr, xfer_cfg}), 64'b11);
      check_output("cfg issue addr", 64'(xfer_addr), 64'h4);
      check_output("cfg issue wdata", xfer_wdata, 64'h5A);
      check_output("cfg issue wmask", 64'(xfer_wmask), 64'h01);
      step();
      core_done = 1'b1; core_rdata = 64'h00000000000000A5;
      step();
      core_done = 1'b0; core_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      check_output("cfg ack", 64'(cfg_ack), 64'd1);
      check_output("cfg bus_ack quiet", 64'(bus_ack), 64'd0);
      check_output("cfg rdata", 64'(cfg_rdata), 64'hA5);
      check_output("cfg bus_rdata unchanged", bus_rdata, 64'd0);
      cfg_req = 1'b0;
      step();
      check_output("cfg rdata held", 64'(cfg_rdata), 64'hA5);

      // Both requests held from reset: cfg, bus, cfg, bus.
      rst_n = 1'b0;
      cfg_req = 1'b1; bus_req = 1'b1; cfg_we = 1'b0; bus_we = 1'b0;
      cfg_addr = 32'h8; bus_addr = 32'h200; recy = 8'd0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check_output($sformatf("rr%0d valid", i), 64'(xfer_valid), 64'd1);
         check_output($sformatf("rr%0d winner cfg", i), 64'(xfer_cfg), 64'((i % 2) == 0));
         step();
         core_done = 1'b1; core_rdata = 64'h0123456789ABCDC0 + 64'(i);
         step();
         core_done = 1'b0;
         check_output($sformatf("rr%0d cfg_ack", i), 64'(cfg_ack), 64'((i % 2) == 0));
         check_output($sformatf("rr%0d bus_ack", i), 64'(bus_ack), 64'((i % 2) == 1));
         check_output($sformatf("rr%0d no valid at ack", i), 64'(xfer_valid), 64'd0);
         if ((i % 2) == 0) begin
            check_output($sformatf("rr%0d cfg_rdata", i), 64'(cfg_rdata), 64'hC0 + 64'(i));
         end else begin
            check_output($sformatf("rr%0d bus_rdata", i), bus_rdata, 64'h0123456789ABCDC0 + 64'(i));
         end
      end
      cfg_req = 1'b0; bus_req = 1'b0;
      step();
      check_output("rr idle after drop", 64'({busy, xfer_valid}), 64'd0);

      // Recovery gap of 5 with a config request arriving during WAIT.
      bus_req = 1'b1; bus_we = 1'b1; recy = 8'd5;
      step();
      check_output("recy issue", 64'({xfer_valid, xfer_cfg}), 64'b10);
      step();
      core_done = 1'b1;
      cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 32'hC; cfg_wdata = 8'h3C;
      step();
      core_done = 1'b0; bus_req = 1'b0;
      check_output("recy bus_ack", 64'(bus_ack), 64'd1);
      for (int k = 0; k < 5; k++) begin
         check_output($sformatf("recy gap%0d busy/valid", k), 64'({busy, xfer_valid}), 64'b10);
         if (k < 4) step();
      end
      recy = 8'd0;
      step();
      check_output("recy idle re-entry", 64'({busy, xfer_valid}), 64'b00);
      step();
      check_output("recy pending issue", 64'({xfer_valid, xfer_cfg, xfer_rdwr}), 64'b110);
      check_output("recy pending wdata", xfer_wdata, 64'h3C);
      step();
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      check_output("recy cfg ack", 64'(cfg_ack), 64'd1);
      cfg_req = 1'b0;
      step();

      // Async reset during WAIT, then restart of the held bus request.
      bus_req = 1'b1; bus_we = 1'b0; bus_addr = 32'h300;
      step();
      step();
      check_output("arst in wait busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("arst");
      step();
      rst_n = 1'b1;
      step();
      check_output("arst restart issue", 64'({xfer_valid, xfer_cfg, xfer_rdwr}), 64'b101);
      check_output("arst restart addr", 64'(xfer_addr), 64'h300);
      step();
      core_done = 1'b1; core_rdata = 64'hDEADBEEF00000042;
      step();
      core_done = 1'b0;
      check_output("arst restart ack", 64'(bus_ack), 64'd1);
      check_output("arst restart rdata", bus_rdata, 64'hDEADBEEF00000042);
      bus_req = 1'b0;
      step();

`ifdef PSRAM_ARB_TIMEOUT_EN
      // Watchdog expiry after 8 WAIT cycles with no done.
      bus_req = 1'b1; bus_we = 1'b0;
      step();
      check_output("to issue", 64'(xfer_valid), 64'd1);
      for (int k = 0; k < 8; k++) begin
         step();
         check_output($sformatf("to wait%0d quiet", k), 64'({err, bus_ack}), 64'd0);
      end
      step();
      check_output("to err/ack", 64'({err, bus_ack}), 64'b11);
      check_output("to rdata zero", bus_rdata, 64'd0);
      bus_req = 1'b0; core_done = 1'b1; core_rdata = 64'h5555;
      step();
      core_done = 1'b0;
      check_output("to late done ignored", 64'({err, bus_ack, busy}), 64'd0);
      check_output("to rdata stays zero", bus_rdata, 64'd0);
`else
      check_output("err tied low", 64'(err), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
